// File: rtl/fifo_burst_reader_if.sv
// Read-side bundle for fifo_burst_reader: the dual-clock FIFO read port
// plus the valid/ready burst stream towards the host pipe-out logic.
//   fifo_rdreq   : read request to the FIFO
//   fifo_rdempty : FIFO empty flag
//   fifo_q       : FIFO read data, valid the cycle after an accepted read
//   fifo_clear   : FIFO clear
//   out_data     : burst word
//   out_valid    : out_data valid
//   out_ready    : consumer accepts when out_valid & out_ready
//   out_last     : final word of a burst, qualified by out_valid
// master = sequencer side, slave = FIFO/consumer side.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rdreq;
  logic                  fifo_rdempty;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_clear;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output fifo_rdreq, fifo_clear, out_data, out_valid, out_last,
    input  fifo_rdempty, fifo_q, out_ready
  );

  modport slave (
    input  fifo_rdreq, fifo_clear, out_data, out_valid, out_last,
    output fifo_rdempty, fifo_q, out_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side sequencer for the dual-clock sample FIFO (read-clock domain).
// Pulls words from the FIFO into a 2-entry skid buffer that absorbs the
// FIFO's one-cycle read latency, and emits fixed BURST_LEN bursts on a
// valid/ready stream. A burst that starves for TIMEOUT cycles is completed
// with PAD_WORD; flush pulses fifo_clear for CLEAR_CYCLES cycles.
// Ports:
//   clk, reset  : read clock, synchronous active-high reset
//   start       : one-burst request (IDLE only)
//   flush       : FIFO clear request (IDLE only, wins over start)
//   bus         : FIFO read port and output stream (master modport)
//   busy        : not IDLE
//   burst_done  : one-cycle pulse after the last word is accepted
//   underrun    : sticky, set when a burst falls back to padding
module fifo_burst_reader #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    BURST_LEN    = 16,
  parameter int                    CNT_WIDTH    = 5,
  parameter int                    TIMEOUT      = 64,
  parameter int                    TO_WIDTH     = 7,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD     = '0,
  parameter int                    CLEAR_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       flush,
  fifo_burst_reader_if.master        bus,
  output logic                       busy,
  output logic                       burst_done,
  output logic                       underrun
);

  localparam int CLR_WIDTH = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [CLR_WIDTH-1:0] CLR_LAST  = CLR_WIDTH'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PAD,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  issue_cnt, send_cnt;
  logic [TO_WIDTH-1:0]   stall_cnt;
  logic [CLR_WIDTH-1:0]  clr_cnt;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic                  underrun_q;

  logic head_valid, pop, pop_buf, rd_accept, stall_inc, room;

  // PAD shows a pad word only once the buffer and any in-flight word are gone.
  assign head_valid = ((state == S_READ) && (buf_count != 2'd0)) ||
                      ((state == S_PAD) && ((buf_count != 2'd0) || !inflight));
  assign pop        = head_valid && bus.out_ready;
  assign pop_buf    = pop && (buf_count != 2'd0);
  assign rd_accept  = bus.fifo_rdreq && !bus.fifo_rdempty;
  assign stall_inc  = (state == S_READ) && (issue_cnt < BURST_CNT) &&
                      bus.fifo_rdempty && !inflight;
  // Occupancy net of the word leaving this cycle, so a steady 1 word/cycle
  // is sustained while never holding more than two words.
  assign room       = ({1'b0, buf_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop});

  assign bus.out_valid = head_valid;
  assign bus.out_data  = !head_valid             ? '0   :
                         (buf_count != 2'd0)     ? buf0 : PAD_WORD;
  assign bus.out_last  = head_valid && (send_cnt == LAST_IDX);
  assign underrun      = underrun_q;

  always_comb begin
    state_nxt      = state;
    bus.fifo_rdreq = 1'b0;
    bus.fifo_clear = 1'b0;
    burst_done     = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (flush)      state_nxt = S_FLUSH;
        else if (start) state_nxt = S_READ;
      end
      S_READ: begin
        bus.fifo_rdreq = (issue_cnt < BURST_CNT) && room && !bus.fifo_rdempty;
        if (pop && (send_cnt == LAST_IDX))             state_nxt = S_DONE;
        else if (stall_inc && (stall_cnt == TO_LAST)) state_nxt = S_PAD;
      end
      S_PAD: begin
        if (pop && (send_cnt == LAST_IDX)) state_nxt = S_DONE;
      end
      S_DONE: begin
        burst_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_FLUSH: begin
        bus.fifo_clear = 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      issue_cnt  <= '0;
      send_cnt   <= '0;
      stall_cnt  <= '0;
      clr_cnt    <= '0;
      inflight   <= 1'b0;
      buf_count  <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
      underrun_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_accept;

      if ((state == S_IDLE) && flush) begin
        buf_count <= 2'd0;
        inflight  <= 1'b0;
      end else begin
        case ({inflight, pop_buf})
          2'b10: begin
            if (buf_count == 2'd0) buf0 <= bus.fifo_q;
            else                   buf1 <= bus.fifo_q;
            buf_count <= buf_count + 2'd1;
          end
          2'b01: begin
            buf0      <= buf1;
            buf_count <= buf_count - 2'd1;
          end
          2'b11: begin
            if (buf_count == 2'd1) buf0 <= bus.fifo_q;
            else begin
              buf0 <= buf1;
              buf1 <= bus.fifo_q;
            end
          end
          default: ;
        endcase
      end

      if (state == S_IDLE) begin
        clr_cnt <= '0;
        if (start && !flush) begin
          issue_cnt  <= '0;
          send_cnt   <= '0;
          stall_cnt  <= '0;
          underrun_q <= 1'b0;
        end
      end
      if (state == S_FLUSH) clr_cnt <= clr_cnt + CLR_WIDTH'(1);

      if (rd_accept) issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      if (pop)       send_cnt  <= send_cnt + CNT_WIDTH'(1);

      if (rd_accept)      stall_cnt <= '0;
      else if (stall_inc) stall_cnt <= stall_cnt + TO_WIDTH'(1);

      if ((state == S_READ) && (state_nxt == S_PAD)) underrun_q <= 1'b1;
    end
  end

endmodule
